// File: rtl/receiver_arm_failsafe_pkg.sv
// Shared definitions for the receiver arm/failsafe slice: arm state encoding
// and stick value constants.
package receiver_arm_failsafe_pkg;

  localparam int PWM_VALUE_BIT_WIDTH = 8;
  localparam int STICK_CENTER_VALUE  = 1 << (PWM_VALUE_BIT_WIDTH - 1);

  typedef enum logic [2:0] {
    ARM_STATE_DISARMED  = 3'd0,
    ARM_STATE_ARMING    = 3'd1,
    ARM_STATE_ARMED     = 3'd2,
    ARM_STATE_DISARMING = 3'd3,
    ARM_STATE_FAILSAFE  = 3'd4
  } arm_state_t;

endpackage

// File: rtl/receiver_arm_failsafe_pwm_link_monitor.sv
// Receiver link monitor: synchronises a raw PWM line, detects rising edges and
// declares the link lost after a saturating timeout without an edge.
module pwm_link_monitor #(
  parameter int LINK_TIMEOUT_US = 100000
) (
  input  logic us_clk,
  input  logic reset,
  input  logic pwm,
  output logic link_ok
);

  localparam int CNT_W = $clog2(LINK_TIMEOUT_US + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LINK_TIMEOUT_US);

  logic             sync_p0;
  logic             sync_p1;
  logic             prev_p2;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign rise = sync_p1 & ~prev_p2;

  // An edge always wins over saturation.
  always_comb begin
    cnt_next = cnt;
    if (rise) begin
      cnt_next = '0;
    end else if (cnt < CNT_MAX) begin
      cnt_next = cnt + 1'b1;
    end
  end

  // p0/p1: metastability synchroniser, p2: previous sample for edge detect
  always_ff @(posedge us_clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      cnt     <= CNT_MAX;
      link_ok <= 1'b0;
    end else begin
      sync_p0 <= pwm;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      cnt     <= cnt_next;
      link_ok <= (cnt_next < CNT_MAX);
    end
  end

endmodule

// File: rtl/receiver_arm_failsafe.sv
// Stick-gesture arm/disarm gate with link-loss failsafe throttle ramp; the
// only sanctioned setpoint source for the attitude controller.
module receiver_arm_failsafe
  import receiver_arm_failsafe_pkg::*;
#(
  parameter int VALUE_WIDTH     = PWM_VALUE_BIT_WIDTH,
  parameter int STICK_LOW_MAX   = 10,
  parameter int STICK_HIGH_MIN  = 245,
  parameter int ARM_HOLD_US     = 1000000,
  parameter int LINK_TIMEOUT_US = 100000,
  parameter int RAMP_STEP_US    = 4000
) (
  input  logic                   us_clk,
  input  logic                   reset,
  input  logic [VALUE_WIDTH-1:0] throttle_val,
  input  logic [VALUE_WIDTH-1:0] yaw_val,
  input  logic [VALUE_WIDTH-1:0] roll_val,
  input  logic [VALUE_WIDTH-1:0] pitch_val,
  input  logic                   throttle_pwm,
  output logic [VALUE_WIDTH-1:0] throttle_out,
  output logic [VALUE_WIDTH-1:0] yaw_out,
  output logic [VALUE_WIDTH-1:0] roll_out,
  output logic [VALUE_WIDTH-1:0] pitch_out,
  output logic                   armed,
  output logic                   failsafe_active,
  output logic                   link_ok
);

  localparam int HOLD_W = (ARM_HOLD_US > 1) ? $clog2(ARM_HOLD_US) : 1;
  localparam int STEP_W = (RAMP_STEP_US > 1) ? $clog2(RAMP_STEP_US) : 1;

  localparam logic [VALUE_WIDTH-1:0] CENTER   = {1'b1, {(VALUE_WIDTH-1){1'b0}}};
  localparam logic [VALUE_WIDTH-1:0] LOW_MAX  = VALUE_WIDTH'(STICK_LOW_MAX);
  localparam logic [VALUE_WIDTH-1:0] HIGH_MIN = VALUE_WIDTH'(STICK_HIGH_MIN);
  localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(ARM_HOLD_US - 1);
  localparam logic [STEP_W-1:0]      STEP_LAST = STEP_W'(RAMP_STEP_US - 1);

  arm_state_t             state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [STEP_W-1:0]      step_cnt;
  logic [VALUE_WIDTH-1:0] fs_thr;
  logic                   arm_g;
  logic                   disarm_g;

  function automatic logic stick_low(input logic [VALUE_WIDTH-1:0] v);
    return v <= LOW_MAX;
  endfunction

  function automatic logic stick_high(input logic [VALUE_WIDTH-1:0] v);
    return v >= HIGH_MIN;
  endfunction

  pwm_link_monitor #(
    .LINK_TIMEOUT_US (LINK_TIMEOUT_US)
  ) u_link_monitor (
    .us_clk  (us_clk),
    .reset   (reset),
    .pwm     (throttle_pwm),
    .link_ok (link_ok)
  );

  assign arm_g    = link_ok & stick_low(throttle_val) & stick_high(yaw_val);
  assign disarm_g = stick_low(throttle_val) & stick_low(yaw_val);

  always_ff @(posedge us_clk) begin
    if (reset) begin
      state           <= ARM_STATE_DISARMED;
      hold_cnt        <= '0;
      step_cnt        <= '0;
      fs_thr          <= '0;
      throttle_out    <= '0;
      yaw_out         <= CENTER;
      roll_out        <= CENTER;
      pitch_out       <= CENTER;
      armed           <= 1'b0;
      failsafe_active <= 1'b0;
    end else begin
      // Outputs follow the current state, one cycle behind it.
      case (state)
        ARM_STATE_ARMED, ARM_STATE_DISARMING: begin
          throttle_out    <= throttle_val;
          yaw_out         <= yaw_val;
          roll_out        <= roll_val;
          pitch_out       <= pitch_val;
          armed           <= 1'b1;
          failsafe_active <= 1'b0;
        end
        ARM_STATE_FAILSAFE: begin
          throttle_out    <= fs_thr;
          yaw_out         <= CENTER;
          roll_out        <= CENTER;
          pitch_out       <= CENTER;
          armed           <= 1'b1;
          failsafe_active <= 1'b1;
        end
        default: begin
          throttle_out    <= '0;
          yaw_out         <= CENTER;
          roll_out        <= CENTER;
          pitch_out       <= CENTER;
          armed           <= 1'b0;
          failsafe_active <= 1'b0;
        end
      endcase

      case (state)
        ARM_STATE_DISARMED: begin
          if (arm_g) begin
            state    <= ARM_STATE_ARMING;
            hold_cnt <= '0;
          end
        end
        ARM_STATE_ARMING: begin
          if (!arm_g) begin
            state    <= ARM_STATE_DISARMED;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= ARM_STATE_ARMED;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ARM_STATE_ARMED: begin
          if (!link_ok) begin
            state    <= ARM_STATE_FAILSAFE;
            fs_thr   <= throttle_out;
            step_cnt <= '0;
            hold_cnt <= '0;
          end else if (disarm_g) begin
            state    <= ARM_STATE_DISARMING;
            hold_cnt <= '0;
          end
        end
        ARM_STATE_DISARMING: begin
          if (!link_ok) begin
            state    <= ARM_STATE_FAILSAFE;
            fs_thr   <= throttle_out;
            step_cnt <= '0;
            hold_cnt <= '0;
          end else if (!disarm_g) begin
            state    <= ARM_STATE_ARMED;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= ARM_STATE_DISARMED;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ARM_STATE_FAILSAFE: begin
          // Ramp runs to zero even if the link comes back.
          if (fs_thr == '0) begin
            state    <= ARM_STATE_DISARMED;
            hold_cnt <= '0;
          end else if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            fs_thr   <= fs_thr - 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ARM_STATE_DISARMED;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receiver_arm_failsafe.sv
// Self-checking bench for receiver_arm_failsafe: directed stick/PWM scenarios
// checked each cycle against a behavioural model plus literal expectations.
module tb_receiver_arm_failsafe;

  localparam int AH  = 20;
  localparam int LT  = 50;
  localparam int RS  = 2;
  localparam int CTR = 128;

  logic       us_clk = 1'b0;
  logic       reset;
  logic [7:0] throttle_val, yaw_val, roll_val, pitch_val;
  logic       throttle_pwm;
  logic [7:0] throttle_out, yaw_out, roll_out, pitch_out;
  logic       armed, failsafe_active, link_ok;

  int errors = 0;
  int checks = 0;

  bit pwm_en  = 1'b0;
  bit pwm_man = 1'b0;

  always #5 us_clk = ~us_clk;

  receiver_arm_failsafe #(
    .VALUE_WIDTH     (8),
    .STICK_LOW_MAX   (10),
    .STICK_HIGH_MIN  (245),
    .ARM_HOLD_US     (AH),
    .LINK_TIMEOUT_US (LT),
    .RAMP_STEP_US    (RS)
  ) dut (
    .us_clk          (us_clk),
    .reset           (reset),
    .throttle_val    (throttle_val),
    .yaw_val         (yaw_val),
    .roll_val        (roll_val),
    .pitch_val       (pitch_val),
    .throttle_pwm    (throttle_pwm),
    .throttle_out    (throttle_out),
    .yaw_out         (yaw_out),
    .roll_out        (roll_out),
    .pitch_out       (pitch_out),
    .armed           (armed),
    .failsafe_active (failsafe_active),
    .link_ok         (link_ok)
  );

  // PWM source: free-running toggle every 10 cycles, or a manually held level.
  int tg_cnt;
  bit tg_lvl;
  initial begin
    throttle_pwm = 1'b0;
    tg_cnt = 0;
    tg_lvl = 1'b0;
    forever begin
      @(posedge us_clk);
      #2;
      if (pwm_en) begin
        tg_cnt++;
        if (tg_cnt == 10) begin
          tg_lvl = !tg_lvl;
          tg_cnt = 0;
        end
        throttle_pwm = tg_lvl;
      end else begin
        tg_lvl = pwm_man;
        tg_cnt = 0;
        throttle_pwm = pwm_man;
      end
    end
  end

  // Behavioural model: armed/failsafe flags, consecutive-gesture streak,
  // ramp level, and cycles since the last synchronised PWM rising edge.
  int e_thr, e_yaw, e_roll, e_pitch;
  bit e_armed, e_fs, e_link;
  bit model_valid = 1'b0;
  bit m_arm, m_fs, h0, h1, h2, g_arm, g_dis;
  int m_streak, m_lvl, m_age, m_since, old_thr;

  initial begin
    forever begin
      @(posedge us_clk);
      if (reset) begin
        m_arm = 0; m_fs = 0; m_streak = 0; m_lvl = 0; m_age = 0;
        m_since = LT; h0 = 0; h1 = 0; h2 = 0;
        e_thr = 0; e_yaw = CTR; e_roll = CTR; e_pitch = CTR;
        e_armed = 0; e_fs = 0; e_link = 0;
        model_valid = 1'b1;
      end else begin
        old_thr = e_thr;
        if (m_fs) begin
          e_thr = m_lvl; e_yaw = CTR; e_roll = CTR; e_pitch = CTR;
          e_armed = 1; e_fs = 1;
        end else if (m_arm) begin
          e_thr = throttle_val; e_yaw = yaw_val; e_roll = roll_val; e_pitch = pitch_val;
          e_armed = 1; e_fs = 0;
        end else begin
          e_thr = 0; e_yaw = CTR; e_roll = CTR; e_pitch = CTR;
          e_armed = 0; e_fs = 0;
        end
        g_arm = e_link && (throttle_val <= 10) && (yaw_val >= 245);
        g_dis = (throttle_val <= 10) && (yaw_val <= 10);
        if (m_fs) begin
          if (m_lvl == 0) begin
            m_fs = 0; m_arm = 0; m_streak = 0;
          end else begin
            m_age++;
            if (m_age % RS == 0) m_lvl--;
          end
        end else if (m_arm) begin
          if (!e_link) begin
            m_fs = 1; m_lvl = old_thr; m_age = 0; m_streak = 0;
          end else if (g_dis) begin
            m_streak++;
            if (m_streak == AH + 1) begin m_arm = 0; m_streak = 0; end
          end else begin
            m_streak = 0;
          end
        end else begin
          if (g_arm) begin
            m_streak++;
            if (m_streak == AH + 1) begin m_arm = 1; m_streak = 0; end
          end else begin
            m_streak = 0;
          end
        end
        if (h1 && !h2) m_since = 0;
        else if (m_since < LT) m_since++;
        h2 = h1; h1 = h0; h0 = throttle_pwm;
        e_link = (m_since < LT);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge us_clk);
    if (model_valid) begin
      check("m_throttle", 32'(throttle_out), e_thr);
      check("m_yaw", 32'(yaw_out), e_yaw);
      check("m_roll", 32'(roll_out), e_roll);
      check("m_pitch", 32'(pitch_out), e_pitch);
      check("m_armed", 32'(armed), 32'(e_armed));
      check("m_failsafe", 32'(failsafe_active), 32'(e_fs));
      check("m_link", 32'(link_ok), 32'(e_link));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sticks(input int t, input int y, input int r, input int p);
    throttle_val = 8'(t);
    yaw_val      = 8'(y);
    roll_val     = 8'(r);
    pitch_val    = 8'(p);
  endtask

  task automatic wait_link(input string name, input int budget);
    int n;
    n = 0;
    while (link_ok !== 1'b1 && n < budget) begin tick(); n++; end
    check(name, 32'(link_ok), 1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    sticks(0, CTR, CTR, CTR);
    ticks(3);
    check("rst_link", 32'(link_ok), 0);
    check("rst_thr", 32'(throttle_out), 0);
    check("rst_yaw", 32'(yaw_out), CTR);
    check("rst_armed", 32'(armed), 0);
    check("rst_fs", 32'(failsafe_active), 0);

    // Link up: link_ok within 3 cycles of the first PWM rising edge
    reset = 1'b0;
    pwm_en = 1'b1;
    n = 0;
    while (throttle_pwm !== 1'b1 && n < 40) begin tick(); n++; end
    wait_link("linkup_3cyc", 3);
    check("linkup_thr", 32'(throttle_out), 0);
    check("linkup_roll", 32'(roll_out), CTR);
    check("linkup_armed", 32'(armed), 0);

    // Arm gesture held: still disarmed after 21 edges, armed after 22
    sticks(0, 255, CTR, CTR);
    ticks(21);
    check("arm_early", 32'(armed), 0);
    tick();
    check("arm_done", 32'(armed), 1);
    sticks(150, CTR, 60, CTR);
    tick();
    check("pass_thr", 32'(throttle_out), 150);
    check("pass_roll", 32'(roll_out), 60);
    check("pass_yaw", 32'(yaw_out), CTR);

    // Disarm aborted at hold cycle 10
    sticks(5, 0, CTR, CTR);
    ticks(11);
    sticks(5, CTR, CTR, CTR);
    ticks(3);
    check("disarm_abort_armed", 32'(armed), 1);
    check("disarm_abort_thr", 32'(throttle_out), 5);

    // Full disarm
    sticks(5, 0, CTR, CTR);
    ticks(22);
    check("disarm_armed", 32'(armed), 0);
    check("disarm_thr", 32'(throttle_out), 0);

    // Arm released at hold cycle 19
    sticks(0, 255, CTR, CTR);
    ticks(20);
    sticks(0, CTR, CTR, CTR);
    ticks(3);
    check("arm_abort", 32'(armed), 0);

    // Failsafe ramp from throttle 6
    sticks(0, 255, CTR, CTR);
    ticks(22);
    check("rearm", 32'(armed), 1);
    sticks(6, CTR, 70, 90);
    ticks(2);
    check("fs_pre_thr", 32'(throttle_out), 6);
    pwm_en = 1'b0;
    pwm_man = 1'b0;
    n = 0;
    while (failsafe_active !== 1'b1 && n < 120) begin tick(); n++; end
    check("fs_entered", 32'(failsafe_active), 1);
    check("fs_thr6", 32'(throttle_out), 6);
    check("fs_roll", 32'(roll_out), CTR);
    check("fs_pitch", 32'(pitch_out), CTR);
    check("fs_link", 32'(link_ok), 0);
    check("fs_armed", 32'(armed), 1);
    ticks(2);
    check("fs_thr5", 32'(throttle_out), 5);
    pwm_en = 1'b1;
    ticks(2);
    check("fs_thr4_link_back", 32'(throttle_out), 4);
    check("fs_still_active", 32'(failsafe_active), 1);
    ticks(9);
    check("fs_end_armed", 32'(armed), 0);
    check("fs_end_thr", 32'(throttle_out), 0);
    check("fs_end_active", 32'(failsafe_active), 0);

    // Link loss in the same cycle the disarm hold completes
    wait_link("relink", 60);
    sticks(0, 255, CTR, CTR);
    ticks(22);
    check("arm3", 32'(armed), 1);
    sticks(0, CTR, CTR, CTR);
    pwm_en = 1'b0;
    pwm_man = 1'b0;
    ticks(4);
    pwm_man = 1'b1;
    ticks(2);
    pwm_man = 1'b0;
    ticks(32);
    sticks(5, 0, CTR, CTR);
    ticks(22);
    check("race_fs", 32'(failsafe_active), 1);
    check("race_armed", 32'(armed), 1);
    check("race_thr", 32'(throttle_out), 5);
    check("race_link", 32'(link_ok), 0);

    // Reset mid-ramp
    ticks(3);
    reset = 1'b1;
    tick();
    check("rst_mid_thr", 32'(throttle_out), 0);
    check("rst_mid_armed", 32'(armed), 0);
    check("rst_mid_fs", 32'(failsafe_active), 0);
    check("rst_mid_link", 32'(link_ok), 0);
    reset = 1'b0;

    // No arming without a link
    sticks(0, 255, CTR, CTR);
    ticks(30);
    check("nolink_armed", 32'(armed), 0);
    check("nolink_link", 32'(link_ok), 0);
    pwm_en = 1'b1;
    ticks(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/receiver_arm_failsafe.md
Name: receiver_arm_failsafe

Overview:
- Sits directly downstream of receiver; consumes its throttle/yaw/roll/pitch values plus the raw throttle PWM line.
- Gates stick values behind a stick-gesture arm/disarm state machine.
- Detects loss of receiver signal and, when armed, drives a controlled throttle ramp-down with the other axes centred.
- Outputs feed the angle/rate controller as the only sanctioned setpoint source.

Parameters:
- VALUE_WIDTH, 8, width of stick values (matches PWM_VALUE_BIT_WIDTH).
- STICK_LOW_MAX, 10, value <= this counts as stick low.
- STICK_HIGH_MIN, 245, value >= this counts as stick high.
- ARM_HOLD_US, 1000000, us_clk cycles a gesture must be held continuously.
- LINK_TIMEOUT_US, 100000, cycles without a throttle_pwm rising edge before the link is lost.
- RAMP_STEP_US, 4000, cycles per 1-LSB failsafe throttle decrement.

Ports:
- us_clk  in  1  1 MHz system clock; only clock.
- reset  in  1  synchronous, active-high reset.
- throttle_val  in  VALUE_WIDTH  from receiver.
- yaw_val  in  VALUE_WIDTH  from receiver.
- roll_val  in  VALUE_WIDTH  from receiver.
- pitch_val  in  VALUE_WIDTH  from receiver.
- throttle_pwm  in  1  raw receiver throttle line (asynchronous).
- throttle_out  out  VALUE_WIDTH  gated throttle setpoint.
- yaw_out  out  VALUE_WIDTH  gated yaw setpoint.
- roll_out  out  VALUE_WIDTH  gated roll setpoint.
- pitch_out  out  VALUE_WIDTH  gated pitch setpoint.
- armed  out  1  motors permitted.
- failsafe_active  out  1  failsafe ramp in progress.
- link_ok  out  1  receiver signal present.

Behaviour:
- CENTER = 2^(VALUE_WIDTH-1), i.e. 128.
- All outputs are registered; 1-cycle latency from inputs and state to outputs.
- Reset values:
  - state = DISARMED.
  - throttle_out = 0; yaw_out, roll_out and pitch_out = CENTER.
  - armed = 0, failsafe_active = 0, link_ok = 0.
  - All counters are cleared. The link counter is reset to the saturated value LINK_TIMEOUT_US, so the link reads as lost.
- Link monitor:
  - 2-flop synchroniser on throttle_pwm, then rising-edge detect.
  - A detected edge clears the link counter to 0. Otherwise the counter increments and saturates at LINK_TIMEOUT_US.
  - link_ok = (counter < LINK_TIMEOUT_US), registered.
  - An edge and saturation in the same cycle resolves to the edge.
- Gestures:
  - ARM_G = link_ok & throttle <= STICK_LOW_MAX & yaw >= STICK_HIGH_MIN.
  - DISARM_G = throttle <= STICK_LOW_MAX & yaw <= STICK_LOW_MAX.
  - hold_cnt clears on every state entry and increments in ARMING and DISARMING.
- State transitions:
  - DISARMED: ARM_G -> ARMING.
  - ARMING: !ARM_G -> DISARMED. hold_cnt == ARM_HOLD_US-1 -> ARMED.
  - ARMED: !link_ok -> FAILSAFE, loading fs_thr = current throttle_out. DISARM_G -> DISARMING.
  - DISARMING: !link_ok -> FAILSAFE, as above. !DISARM_G -> ARMED. hold_cnt == ARM_HOLD_US-1 -> DISARMED.
  - FAILSAFE: a step counter decrements fs_thr by 1 every RAMP_STEP_US cycles, floored at 0. fs_thr == 0 -> DISARMED, regardless of link state.
  - Returning link does not abort failsafe. Re-arming requires a fresh gesture from DISARMED.
  - Priority: link loss overrides any gesture in the same cycle.
- Outputs per state:
  - DISARMED, ARMING: throttle 0; other axes CENTER; armed = 0.
  - ARMED, DISARMING: pass-through of the input values; armed = 1.
  - FAILSAFE: throttle = fs_thr; other axes CENTER; armed = 1; failsafe_active = 1.
- Entering FAILSAFE with throttle_out already 0 exits to DISARMED on the next cycle.
- Reset asserted mid-operation (any state, including mid-ramp) returns to reset values on the next edge. The link must be re-established before arming.
- Widths:
  - hold_cnt is $clog2(ARM_HOLD_US) bits.
  - The link counter is $clog2(LINK_TIMEOUT_US+1) bits.
  - No arithmetic on stick values except the fs_thr decrement, which never underflows.

Decomposition:
- common_defines:
  - Add the state encoding macros ARM_STATE_DISARMED, ARMING, ARMED, DISARMING, FAILSAFE (3 bits).
  - Add STICK_CENTER_VALUE.
  - Reuse PWM_VALUE_BIT_WIDTH.
- One sub-module: pwm_link_monitor (synchroniser, edge detect, saturating timeout counter, link_ok). It is reusable on other channels later.
- The FSM, gesture compare, hold counter, ramp and output mux stay in receiver_arm_failsafe.

Test Plan:
Run with ARM_HOLD_US=20, LINK_TIMEOUT_US=50, RAMP_STEP_US=2, and throttle_pwm toggling every 10 cycles (link up).
- Reset then link up: link_ok=0 after reset. Rises within 3 cycles of the first throttle_pwm edge. Outputs stay throttle 0 and axes 128, armed=0.
- Arm: throttle 0, yaw 255 held 20 cycles -> armed=1. Then throttle 150, roll 60 -> throttle_out 150, roll_out 60 one cycle later. Releasing yaw at hold cycle 19 -> DISARMED, armed stays 0.
- Disarm: while armed, throttle 5, yaw 0 for 20 cycles -> armed=0, throttle_out 0. Raising yaw at hold cycle 10 -> stays ARMED.
- Failsafe ramp: armed with throttle 6, then stop throttle_pwm.
  - 50 cycles later: link_ok=0, failsafe_active=1, throttle_out=6, axes 128.
  - Throttle_out decrements every 2 cycles to 0, then armed=0.
  - Restarting pwm mid-ramp does not stop the ramp.
- Simultaneous events and reset:
  - Link loss in the same cycle as a completed DISARM hold -> FAILSAFE.
  - Reset asserted mid-ramp -> next cycle throttle_out 0, armed=0, failsafe_active=0, link_ok=0.
